// File: rtl/rvfi_retire_tracker_pkg.sv
// Shared types for the multi-core RVFI retirement tracker.
//   trk_state_t : fault-capture FSM states
//   WDT_CODE    : error code reported when a watchdog (not the monitor) fires
//   trk_err_t   : captured-fault record at the default widths, for harness-side
//                 code that wants the record as one value
package psp_trace_pkg;

    typedef enum logic {
        TRK_RUN   = 1'b0,
        TRK_FAULT = 1'b1
    } trk_state_t;

    localparam logic [15:0] WDT_CODE = 16'hFFFF;

    typedef struct packed {
        logic [2:0]  core;
        logic [15:0] code;
        logic [63:0] order;
        logic [31:0] pc;
    } trk_err_t;

endpackage

// File: rtl/rvfi_retire_tracker_if.sv
// Bus between the cores/rvfimon side (master) and the tracker (slave).
//   master drives: rvfi_valid, rvfi_pc_rdata, core_sleeping, mon_errcode, err_clear
//   slave drives : order, total_retired, pc_last, wdt_fire, err_* and halt_req
interface rvfi_retire_tracker_if #(
    parameter int NUM_CORES = 2,
    parameter int XLEN      = 32,
    parameter int ORDER_W   = 64,
    parameter int ERR_W     = 16
);
    logic [NUM_CORES-1:0]              rvfi_valid;
    logic [NUM_CORES-1:0][XLEN-1:0]    rvfi_pc_rdata;
    logic [NUM_CORES-1:0]              core_sleeping;
    logic [NUM_CORES-1:0][ERR_W-1:0]   mon_errcode;
    logic                              err_clear;

    logic [NUM_CORES-1:0][ORDER_W-1:0] order;
    logic [ORDER_W-1:0]                total_retired;
    logic [NUM_CORES-1:0][XLEN-1:0]    pc_last;
    logic [NUM_CORES-1:0]              wdt_fire;
    logic                              err_valid;
    logic [2:0]                        err_core;
    logic [ERR_W-1:0]                  err_code;
    logic [ORDER_W-1:0]                err_order;
    logic [XLEN-1:0]                   err_pc;
    logic                              halt_req;

    modport master (
        output rvfi_valid, rvfi_pc_rdata, core_sleeping, mon_errcode, err_clear,
        input  order, total_retired, pc_last, wdt_fire, err_valid, err_core,
               err_code, err_order, err_pc, halt_req
    );

    modport slave (
        input  rvfi_valid, rvfi_pc_rdata, core_sleeping, mon_errcode, err_clear,
        output order, total_retired, pc_last, wdt_fire, err_valid, err_core,
               err_code, err_order, err_pc, halt_req
    );
endinterface

// File: rtl/rvfi_retire_tracker_counter.sv
// Per-core retirement bookkeeping: RVFI order counter, last retired PC and a
// no-retire watchdog. Raises err_req with the code to report for this core.
//   clk, reset        : clock, async active-high reset
//   valid, pc_rdata   : retirement strobe and PC of the retiring instruction
//   sleeping          : core is in WFI, watchdog held cleared
//   errcode           : rvfimon error code, nonzero = error
//   order, pc_last    : order of the next retirement, PC of the last one
//   wdt_fire          : watchdog saturated at its limit (level)
//   err_req, err_code : this core has an error source and its code
module rvfi_core_counter
    import psp_trace_pkg::*;
#(
    parameter int               XLEN      = 32,
    parameter int               ORDER_W   = 64,
    parameter int               ERR_W     = 16,
    parameter int               WDT_W     = 20,
    parameter logic [WDT_W-1:0] WDT_LIMIT = 20'hFFFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid,
    input  logic [XLEN-1:0]    pc_rdata,
    input  logic               sleeping,
    input  logic [ERR_W-1:0]   errcode,
    output logic [ORDER_W-1:0] order,
    output logic [XLEN-1:0]    pc_last,
    output logic               wdt_fire,
    output logic               err_req,
    output logic [ERR_W-1:0]   err_code
);
    localparam logic [ERR_W-1:0] WDT_ERR = ERR_W'(WDT_CODE);

    logic [WDT_W-1:0] wdt_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            order   <= '0;
            pc_last <= '0;
            wdt_cnt <= '0;
        end else begin
            if (valid) begin
                order   <= order + 1'b1;
                pc_last <= pc_rdata;
            end
            // A limit of zero keeps the counter parked at 0, so it never fires.
            if (valid || sleeping || (WDT_LIMIT == '0))
                wdt_cnt <= '0;
            else if (wdt_cnt != WDT_LIMIT)
                wdt_cnt <= wdt_cnt + 1'b1;
        end
    end

    assign wdt_fire = (WDT_LIMIT != '0) && (wdt_cnt == WDT_LIMIT);

    // Monitor code takes precedence over the watchdog within one core.
    assign err_req  = (|errcode) || wdt_fire;
    assign err_code = (|errcode) ? errcode : WDT_ERR;

endmodule

// File: rtl/rvfi_retire_tracker.sv
// Multi-core RVFI retirement tracker. Keeps per-core order/PC/watchdog state,
// a wrapping total of retirements, and captures the first error seen on any
// core (lowest index wins) into sticky err_* registers with halt_req.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of rvfi_retire_tracker_if (inputs from cores and
//                rvfimon, err_clear from the harness; counters, fault record
//                and halt_req back out)
module rvfi_retire_tracker
    import psp_trace_pkg::*;
#(
    parameter int               NUM_CORES = 2,
    parameter int               XLEN      = 32,
    parameter int               ORDER_W   = 64,
    parameter int               ERR_W     = 16,
    parameter int               WDT_W     = 20,
    parameter logic [WDT_W-1:0] WDT_LIMIT = 20'hFFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    rvfi_retire_tracker_if.slave  bus
);
    logic [NUM_CORES-1:0][ORDER_W-1:0] order_q;
    logic [NUM_CORES-1:0][XLEN-1:0]    pc_last_q;
    logic [NUM_CORES-1:0]              req;
    logic [NUM_CORES-1:0][ERR_W-1:0]   req_code;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        rvfi_core_counter #(
            .XLEN     (XLEN),
            .ORDER_W  (ORDER_W),
            .ERR_W    (ERR_W),
            .WDT_W    (WDT_W),
            .WDT_LIMIT(WDT_LIMIT)
        ) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .valid    (bus.rvfi_valid[g]),
            .pc_rdata (bus.rvfi_pc_rdata[g]),
            .sleeping (bus.core_sleeping[g]),
            .errcode  (bus.mon_errcode[g]),
            .order    (order_q[g]),
            .pc_last  (pc_last_q[g]),
            .wdt_fire (bus.wdt_fire[g]),
            .err_req  (req[g]),
            .err_code (req_code[g])
        );
    end

    assign bus.order   = order_q;
    assign bus.pc_last = pc_last_q;

    // Priority encoder: walking downwards lets the lowest requesting core win.
    logic               sel_hit;
    logic [2:0]         sel_idx;
    logic [ERR_W-1:0]   sel_code;
    logic [ORDER_W-1:0] sel_order;
    logic [XLEN-1:0]    sel_pc;

    always_comb begin
        sel_hit   = 1'b0;
        sel_idx   = '0;
        sel_code  = '0;
        sel_order = '0;
        sel_pc    = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel_hit   = 1'b1;
                sel_idx   = 3'(i);
                sel_code  = req_code[i];
                sel_order = order_q[i];
                sel_pc    = pc_last_q[i];
            end
        end
    end

    // Popcount of this cycle's retirements.
    logic [ORDER_W-1:0] retire_cnt;
    always_comb begin
        retire_cnt = '0;
        for (int i = 0; i < NUM_CORES; i++)
            retire_cnt = retire_cnt + ORDER_W'(bus.rvfi_valid[i]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) bus.total_retired <= '0;
        else       bus.total_retired <= bus.total_retired + retire_cnt;
    end

    // Fault-capture FSM.
    trk_state_t state, state_nxt;
    logic       capture, clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= TRK_RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        clear     = 1'b0;
        case (state)
            TRK_RUN: begin
                if (sel_hit) begin
                    capture   = 1'b1;
                    state_nxt = TRK_FAULT;
                end
            end
            TRK_FAULT: begin
                // Errors present in the clear cycle are deliberately dropped;
                // a persistent one is picked up again from RUN next cycle.
                if (bus.err_clear) begin
                    clear     = 1'b1;
                    state_nxt = TRK_RUN;
                end
            end
            default: state_nxt = TRK_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.err_core  <= '0;
            bus.err_code  <= '0;
            bus.err_order <= '0;
            bus.err_pc    <= '0;
        end else if (capture) begin
            bus.err_core  <= sel_idx;
            bus.err_code  <= sel_code;
            bus.err_order <= sel_order;
            bus.err_pc    <= sel_pc;
        end else if (clear) begin
            bus.err_core  <= '0;
            bus.err_code  <= '0;
            bus.err_order <= '0;
            bus.err_pc    <= '0;
        end
    end

    assign bus.err_valid = (state == TRK_FAULT);
    assign bus.halt_req  = (state == TRK_FAULT);

endmodule

// File: tb/tb_rvfi_retire_tracker.sv
// Scoreboard bench for rvfi_retire_tracker. Stimulus updates a behavioural
// model per clock and queues the expected post-edge outputs; a monitor pops
// and compares after each rising edge. ORDER_W is reduced to 8 so the order
// and total counters can be driven through their wrap point.
module tb_rvfi_retire_tracker;
    import psp_trace_pkg::*;

    localparam int               NC  = 2;
    localparam int               XL  = 32;
    localparam int               OW  = 8;
    localparam int               EW  = 16;
    localparam int               WW  = 20;
    localparam logic [WW-1:0]    LIM = 20'd8;
    localparam int               LIM_I = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rvfi_retire_tracker_if #(.NUM_CORES(NC), .XLEN(XL), .ORDER_W(OW), .ERR_W(EW)) bus ();

    rvfi_retire_tracker #(
        .NUM_CORES(NC), .XLEN(XL), .ORDER_W(OW), .ERR_W(EW), .WDT_W(WW), .WDT_LIMIT(LIM)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [NC-1:0][OW-1:0] ord;
        logic [OW-1:0]         tot;
        logic [NC-1:0][XL-1:0] pcl;
        logic [NC-1:0]         fire;
        logic                  fault;
        logic [2:0]            core;
        logic [EW-1:0]         code;
        logic [OW-1:0]         eord;
        logic [XL-1:0]         epc;
    } snap_t;

    snap_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    // Reference model state
    logic [OW-1:0] ord_m [NC];
    logic [XL-1:0] pcl_m [NC];
    int            idle_m[NC];
    logic [OW-1:0] tot_m;
    bit            faulted;
    trk_err_t      rec;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            ord_m[i] = '0; pcl_m[i] = '0; idle_m[i] = 0;
        end
        tot_m = '0; faulted = 0; rec = '0;
    endtask

    // One clock edge of the intended behaviour, using the inputs now driven.
    task automatic model_edge();
        int hit = -1;
        if (!faulted) begin
            for (int i = 0; i < NC; i++)
                if (hit < 0 && (bus.mon_errcode[i] != 0 || idle_m[i] == LIM_I)) hit = i;
            if (hit >= 0) begin
                faulted   = 1;
                rec.core  = 3'(hit);
                rec.code  = (bus.mon_errcode[hit] != 0) ? bus.mon_errcode[hit] : 16'hFFFF;
                rec.order = 64'(ord_m[hit]);
                rec.pc    = pcl_m[hit];
            end
        end else if (bus.err_clear) begin
            faulted = 0;
            rec     = '0;
        end
        for (int i = 0; i < NC; i++) begin
            if (bus.rvfi_valid[i]) begin
                ord_m[i] = ord_m[i] + 1'b1;
                pcl_m[i] = bus.rvfi_pc_rdata[i];
            end
            if (bus.rvfi_valid[i] || bus.core_sleeping[i]) idle_m[i] = 0;
            else if (idle_m[i] < LIM_I)                    idle_m[i]++;
        end
        tot_m = tot_m + OW'($countones(bus.rvfi_valid));
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        for (int i = 0; i < NC; i++) begin
            s.ord[i]  = ord_m[i];
            s.pcl[i]  = pcl_m[i];
            s.fire[i] = (idle_m[i] == LIM_I);
        end
        s.tot   = tot_m;
        s.fault = faulted;
        s.core  = rec.core;
        s.code  = rec.code;
        s.eord  = rec.order[OW-1:0];
        s.epc   = rec.pc;
        return s;
    endfunction

    // Drive one cycle's inputs at the falling edge and queue the expectation.
    task automatic step(input logic [NC-1:0] v, input logic [XL-1:0] p0, input logic [XL-1:0] p1,
                        input logic [NC-1:0] slp, input logic [EW-1:0] e0, input logic [EW-1:0] e1,
                        input logic clr);
        bus.rvfi_valid       = v;
        bus.rvfi_pc_rdata[0] = p0;
        bus.rvfi_pc_rdata[1] = p1;
        bus.core_sleeping    = slp;
        bus.mon_errcode[0]   = e0;
        bus.mon_errcode[1]   = e1;
        bus.err_clear        = clr;
        model_edge();
        exp_q.push_back(model_snap());
        @(negedge clk);
    endtask

    task automatic quiet(input int n);
        for (int k = 0; k < n; k++) step(2'b00, 0, 0, 2'b11, 0, 0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < NC; i++) begin
            chk($sformatf("%s order[%0d]", tag, i), 64'(bus.order[i]), 0);
            chk($sformatf("%s pc_last[%0d]", tag, i), 64'(bus.pc_last[i]), 0);
        end
        chk({tag, " total"},     64'(bus.total_retired), 0);
        chk({tag, " wdt_fire"},  64'(bus.wdt_fire), 0);
        chk({tag, " err_valid"}, 64'(bus.err_valid), 0);
        chk({tag, " halt_req"},  64'(bus.halt_req), 0);
        chk({tag, " err_core"},  64'(bus.err_core), 0);
        chk({tag, " err_code"},  64'(bus.err_code), 0);
        chk({tag, " err_order"}, 64'(bus.err_order), 0);
        chk({tag, " err_pc"},    64'(bus.err_pc), 0);
    endtask

    // Asynchronous reset raised between edges; outputs must clear at once.
    task automatic reset_dut(input string tag);
        #2;
        reset = 1'b1;
        #1;
        check_zero(tag);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: compare DUT against the queued expectation after every edge.
    snap_t e;
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < NC; i++) begin
                chk($sformatf("order[%0d]", i),   64'(bus.order[i]),   64'(e.ord[i]));
                chk($sformatf("pc_last[%0d]", i), 64'(bus.pc_last[i]), 64'(e.pcl[i]));
            end
            chk("total_retired", 64'(bus.total_retired), 64'(e.tot));
            chk("wdt_fire",      64'(bus.wdt_fire),      64'(e.fire));
            chk("err_valid",     64'(bus.err_valid),     64'(e.fault));
            chk("halt_req",      64'(bus.halt_req),      64'(e.fault));
            chk("err_core",      64'(bus.err_core),      64'(e.core));
            chk("err_code",      64'(bus.err_code),      64'(e.code));
            chk("err_order",     64'(bus.err_order),     64'(e.eord));
            chk("err_pc",        64'(bus.err_pc),        64'(e.epc));
        end
    end

    initial begin
        bus.rvfi_valid    = '0;
        bus.rvfi_pc_rdata = '0;
        bus.core_sleeping = '0;
        bus.mon_errcode   = '0;
        bus.err_clear     = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        // Core0 retires three instructions.
        step(2'b01, 32'h100, 0, 2'b10, 0, 0, 0);
        step(2'b01, 32'h104, 0, 2'b10, 0, 0, 0);
        step(2'b01, 32'h108, 0, 2'b10, 0, 0, 0);
        quiet(2);

        // Both cores retire together.
        reset_dut("rst2");
        for (int k = 0; k < 5; k++) step(2'b11, 32'h400 + 4*k, 32'h800 + 4*k, 2'b00, 0, 0, 0);
        quiet(2);

        // Core1 monitor error after 7 retirements; later core0 error ignored.
        reset_dut("rst3");
        for (int k = 0; k < 7; k++) step(2'b10, 0, 32'h1E8 + 4*k, 2'b01, 0, 0, 0);
        step(2'b00, 0, 0, 2'b11, 0, 16'h0021, 0);
        step(2'b00, 0, 0, 2'b11, 16'h0005, 0, 0);
        quiet(2);
        step(2'b00, 0, 0, 2'b11, 0, 0, 1);

        // Simultaneous errors, clear with persistent error, recapture.
        step(2'b00, 0, 0, 2'b11, 16'h0003, 16'h0004, 0);
        step(2'b00, 0, 0, 2'b11, 16'h0003, 0, 1);
        step(2'b00, 0, 0, 2'b11, 16'h0003, 0, 0);
        step(2'b00, 0, 0, 2'b11, 0, 0, 1);
        step(2'b00, 0, 0, 2'b11, 0, 0, 1);

        // Watchdog on awake core0, then the same with it sleeping.
        for (int k = 0; k < 12; k++) step(2'b00, 0, 0, 2'b10, 0, 0, 0);
        step(2'b00, 0, 0, 2'b11, 0, 0, 1);
        for (int k = 0; k < 12; k++) step(2'b00, 0, 0, 2'b11, 0, 0, 0);

        // Reset while faulted.
        step(2'b01, 32'h44, 0, 2'b10, 16'h0001, 0, 0);
        quiet(1);
        reset_dut("rst_fault");

        // Order and total wrap.
        for (int k = 0; k < 260; k++) step(2'b01, 32'(k), 0, 2'b10, 0, 0, 0);
        quiet(1);

        // Randomised traffic.
        for (int k = 0; k < 500; k++) begin
            logic [EW-1:0] e0, e1;
            e0 = ($urandom_range(0, 19) == 0) ? EW'($urandom_range(1, 65535)) : '0;
            e1 = ($urandom_range(0, 19) == 0) ? EW'($urandom_range(1, 65535)) : '0;
            step(NC'($urandom_range(0, 3)), $urandom, $urandom,
                 ($urandom_range(0, 3) == 0) ? NC'($urandom_range(0, 3)) : '0,
                 e0, e1, ($urandom_range(0, 5) == 0));
        end

        @(posedge clk);
        #3;
        chk("scoreboard drained", 64'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rvfi_retire_tracker.md
Name: rvfi_retire_tracker

Overview:
Parametrised multi-core retirement tracker. It generalises the single-core instruction-order counter and error-code stop logic to NUM_CORES RVFI channels. Per core it keeps an RVFI order counter, the last retired PC and a no-retire watchdog. It captures the first error across all cores (monitor errcode or watchdog) with core index, order and PC, then raises a sticky halt request for the simulation harness. It sits in the top-level verification wrapper, between core RVFI outputs/rvfimon instances and the C++ step loop.

Parameters:
NUM_CORES, 2, number of RVFI channels (1..8)
XLEN, 32, PC width
ORDER_W, 64, per-core order counter width
ERR_W, 16, monitor error code width
WDT_W, 20, watchdog counter width
WDT_LIMIT, 20'hFFFFF, cycles without retirement (core awake) before watchdog fires; 0 disables

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
rvfi_valid  in  NUM_CORES  per-core retirement strobe
rvfi_pc_rdata  in  NUM_CORES*XLEN  per-core PC of retiring instruction
core_sleeping  in  NUM_CORES  per-core WFI indication
mon_errcode  in  NUM_CORES*ERR_W  per-core rvfimon error code; nonzero = error
err_clear  in  1  acknowledge/clear captured fault
order  out  NUM_CORES*ORDER_W  per-core order of the next retirement (feeds rvfimon rvfi_order)
total_retired  out  ORDER_W  sum of retirements across all cores
pc_last  out  NUM_CORES*XLEN  PC of each core's most recent retirement
wdt_fire  out  NUM_CORES  per-core watchdog expired (level)
err_valid  out  1  fault captured (equals halt_req)
err_core  out  3  index of faulting core
err_code  out  ERR_W  captured code (WDT_CODE for watchdog)
err_order  out  ORDER_W  order value of faulting core at capture
err_pc  out  XLEN  pc_last of faulting core at capture
halt_req  out  1  harness must stop stepping

Behaviour:
- Reset applies asynchronously. It sets every output and every internal register to 0 and the FSM to RUN.
- Order counters:
  - order[i] increments by 1 on each clk where rvfi_valid[i]=1.
  - The value driven in the same cycle as valid is the pre-increment value, so the first retirement reports 0.
  - Counters wrap modulo 2^ORDER_W. They keep counting in FAULT.
- total_retired adds popcount(rvfi_valid) each cycle. Width is ORDER_W; it wraps.
- pc_last[i] loads rvfi_pc_rdata[i] on valid, 1-cycle latency.
- Watchdog per core:
  - wdt_cnt clears on valid, on core_sleeping, or when WDT_LIMIT=0.
  - Otherwise it increments, saturating at WDT_LIMIT.
  - wdt_fire[i]=1 while wdt_cnt==WDT_LIMIT and WDT_LIMIT!=0.
  - Valid clears the count the same cycle it is sampled; wdt_fire drops the next cycle.
- Error source for core i: mon_errcode[i]!=0, else wdt_fire[i] (code WDT_CODE).
- FSM RUN:
  - If any source is active, capture into err_* on that clk edge and go to FAULT.
  - Simultaneous sources: the lowest core index wins. Within a core, the monitor code beats the watchdog.
  - err_order/err_pc take order[i]/pc_last[i] as registered before that edge.
- FSM FAULT:
  - err_valid=halt_req=1 and err_* are frozen; further errors are ignored.
  - err_clear=1 zeroes err_* and returns to RUN.
  - Errors present in the clear cycle are not captured; they are captured next cycle if still asserted.
- err_clear in RUN: no effect.
- Reset mid-FAULT: everything returns to reset values; no capture survives.
- err_core width is fixed at 3; upper bits are 0 when NUM_CORES<8.

Decomposition:
- Package psp_trace_pkg holds:
  - enum trk_state_t {TRK_RUN, TRK_FAULT}
  - WDT_CODE = 16'hFFFF, sized to ERR_W
  - struct trk_err_t {core, code, order, pc}
- Sub-module rvfi_core_counter, instantiated once per core by generate loop. It holds order, pc_last, wdt_cnt and wdt_fire, and outputs a per-core error request plus code.
- The top holds the priority encoder, popcount/total, FSM and capture registers.

Test Plan:
- Reset, then valid on core0 for 3 cycles with pc 0x100/0x104/0x108 -> order[0] seen as 0,1,2 during valid; then 3. pc_last[0]=0x108. total_retired=3.
- Cores 0 and 1 valid simultaneously for 5 cycles -> order[0]=order[1]=5, total_retired=10.
- Core1 mon_errcode=0x0021 after 7 core1 retirements (last pc 0x200) -> next edge: err_valid=halt_req=1, err_core=1, err_code=0x0021, err_order=7, err_pc=0x200. A later core0 error is ignored.
- Core0 and core1 errcodes both nonzero in one cycle -> err_core=0. err_clear pulse -> err_valid=0 next cycle. Persistent error recaptured one cycle after that.
- WDT_LIMIT=8, core0 awake with no valid -> wdt_fire[0] after 8 cycles and capture with err_code=0xFFFF. Repeat with core_sleeping=1 -> no fire.
- Reset asserted in FAULT between clk edges -> all outputs 0 immediately, FSM RUN. Order counter preset near 2^ORDER_W-1 -> wraps to 0.
